// File: rtl/mem_multicycle_ctrl.sv
// Multi-cycle data-memory sequencer: runs the start/done bus handshake for SDRAM/I/O
// accesses, stalls the MEM stage, aborts on timeout and error-completes unmapped requests.
module mem_multicycle_ctrl #(
    parameter int TIMEOUT = 1023,
    parameter int CW      = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic        mem_sdram,
    input  logic        mem_io,
    input  logic        mem_rom,
    input  logic        mem_vram32,
    input  logic        mem_vram8,
    input  logic        mem_vrampx,
    input  logic        mem_multicycle,
    input  logic [31:0] mem_local_address,
    output logic        bus_start,
    output logic        bus_we,
    output logic        bus_io,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data,
    input  logic        bus_done,
    input  logic [31:0] bus_q,
    output logic        stall,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            err_r;
    logic            no_region;
    logic            timeout_hit;

    assign no_region   = ~(mem_sdram | mem_io | mem_rom | mem_vram32 | mem_vram8 | mem_vrampx);
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req && mem_multicycle) state_nxt = S_ISSUE;
                else if (req && no_region) state_nxt = S_DONE;
            end
            S_ISSUE: state_nxt = S_WAIT;
            // bus_done takes priority over a coincident timeout (handled in the datapath)
            S_WAIT:  if (bus_done || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus_start = 1'b0;
        ack       = 1'b0;
        err       = 1'b0;
        busy      = 1'b1;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                busy  = 1'b0;
                stall = req & (mem_multicycle | no_region);
            end
            S_ISSUE: begin
                bus_start = 1'b1;
                stall     = 1'b1;
            end
            S_WAIT:  stall = 1'b1;
            S_DONE: begin
                ack = 1'b1;
                err = err_r;
            end
            default: busy = 1'b0;
        endcase
    end

    // Bus registers only load on IDLE->ISSUE, so they stay stable until ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_we   <= 1'b0;
            bus_io   <= 1'b0;
            bus_addr <= '0;
            bus_data <= '0;
            cnt      <= '0;
            rdata    <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && mem_multicycle) begin
                        bus_we   <= we;
                        bus_io   <= mem_io;
                        bus_addr <= mem_local_address;
                        bus_data <= wdata;
                    end else if (req && no_region) begin
                        err_r <= 1'b1;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus_done) begin
                        rdata <= bus_we ? 32'h0 : bus_q;
                        err_r <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata <= 32'h0;
                        err_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
